// File: rtl/config_serializer_if.sv
// Parallel word handshake between the configuration controller and the serializer.
interface config_serializer_if #(
  parameter int WORD = 8
);
  logic [WORD-1:0] word_in;
  logic            word_valid;
  logic            word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/config_serializer.sv
// Serial configuration chain transmitter: shifts each accepted word out LSB-first on
// sdo with a generated sclk, and pulses done after a frame of NUM_WORDS words.
//
// state | meaning
// IDLE  | no frame in progress, ready for the first word of a frame
// LOAD  | between words of a frame, sclk low, sdo holds last bit, ready for next word
// SHIFT | shifting the current word, HALF cycles low then HALF cycles high per bit
// DONE  | one-cycle done pulse, then back to IDLE
module config_serializer #(
  parameter int WORD      = 8,
  parameter int NUM_WORDS = 4,
  parameter int HALF      = 1
) (
  input  logic                clk,
  input  logic                reset,
  config_serializer_if.slave  bus,
  output logic                sclk,
  output logic                sdo,
  output logic                busy,
  output logic                done
);
  localparam int BIT_W  = $clog2(WORD);
  localparam int WCNT_W = $clog2(NUM_WORDS) + 1;
  localparam int DIV_W  = $clog2(HALF) + 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD-1:0]   shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              accept;

  assign bus.word_ready = ((state == IDLE) || (state == LOAD)) && !reset;
  assign accept         = bus.word_valid && bus.word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            shreg   <= bus.word_in;
            sdo     <= bus.word_in[0];
            sclk    <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
            state   <= SHIFT;
            if (state == IDLE) begin
              word_cnt <= '0;
              busy     <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // div_cnt times each sclk phase; sdo only moves on the falling edge
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                if (word_cnt == LAST_WORD) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  word_cnt <= word_cnt + WCNT_W'(1);
                  state    <= LOAD;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shreg   <= shreg >> 1;
                sdo     <= shreg[1];
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          sdo   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_serializer.sv
// Bench for config_serializer: three instances with different frame/timing parameters,
// an ideal receiver chain per instance, and a word scoreboard.
module tb_config_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  config_serializer_if #(.WORD(8)) bus_a ();
  config_serializer_if #(.WORD(8)) bus_b ();
  config_serializer_if #(.WORD(8)) bus_c ();

  logic sclk_a, sdo_a, busy_a, done_a;
  logic sclk_b, sdo_b, busy_b, done_b;
  logic sclk_c, sdo_c, busy_c, done_c;

  config_serializer #(.WORD(8), .NUM_WORDS(1), .HALF(1)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a.slave),
    .sclk(sclk_a), .sdo(sdo_a), .busy(busy_a), .done(done_a));
  config_serializer #(.WORD(8), .NUM_WORDS(4), .HALF(1)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b.slave),
    .sclk(sclk_b), .sdo(sdo_b), .busy(busy_b), .done(done_b));
  config_serializer #(.WORD(8), .NUM_WORDS(2), .HALF(3)) dut_c (
    .clk(clk), .reset(rst), .bus(bus_c.slave),
    .sclk(sclk_c), .sdo(sdo_c), .busy(busy_c), .done(done_c));

  // expected and received words per instance
  logic [7:0] exp_q[3][$];
  logic [7:0] rx_q[3][$];

  // ideal receiver chains: sdi in at MSB, shift right on sclk rise
  logic [7:0] chain_a = '0, chain_b = '0, chain_c = '0, seq_a = '0;
  int rises_a = 0, rises_b = 0, rises_c = 0;
  int nbit_a = 0, nbit_b = 0, nbit_c = 0;
  int dones_a = 0, dones_b = 0, dones_c = 0;

  always @(posedge sclk_a or posedge rst) begin
    if (rst) nbit_a = 0;
    else begin
      rises_a++;
      seq_a   = {seq_a[6:0], sdo_a};
      chain_a = {sdo_a, chain_a[7:1]};
      nbit_a++;
      if (nbit_a == 8) begin rx_q[0].push_back(chain_a); nbit_a = 0; end
    end
  end
  always @(posedge sclk_b or posedge rst) begin
    if (rst) nbit_b = 0;
    else begin
      rises_b++;
      chain_b = {sdo_b, chain_b[7:1]};
      nbit_b++;
      if (nbit_b == 8) begin rx_q[1].push_back(chain_b); nbit_b = 0; end
    end
  end
  always @(posedge sclk_c or posedge rst) begin
    if (rst) nbit_c = 0;
    else begin
      rises_c++;
      chain_c = {sdo_c, chain_c[7:1]};
      nbit_c++;
      if (nbit_c == 8) begin rx_q[2].push_back(chain_c); nbit_c = 0; end
    end
  end
  always @(posedge clk) begin
    if (done_a) dones_a++;
    if (done_b) dones_b++;
    if (done_c) dones_c++;
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;  // sdo at successive sclk rises, first rise in the MSB
    int         lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int id);
    case (id)
      0: return bus_a.word_ready;
      1: return bus_b.word_ready;
      default: return bus_c.word_ready;
    endcase
  endfunction

  function automatic logic dn(input int id);
    case (id)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [4:0] stat(input int id);
    case (id)
      0: return {sclk_a, sdo_a, busy_a, done_a, bus_a.word_ready};
      1: return {sclk_b, sdo_b, busy_b, done_b, bus_b.word_ready};
      default: return {sclk_c, sdo_c, busy_c, done_c, bus_c.word_ready};
    endcase
  endfunction

  task automatic set_in(input int id, input logic v, input logic [7:0] w);
    case (id)
      0: begin bus_a.word_valid = v; bus_a.word_in = w; end
      1: begin bus_b.word_valid = v; bus_b.word_in = w; end
      default: begin bus_c.word_valid = v; bus_c.word_in = w; end
    endcase
  endtask

  task automatic send(input int id, input logic [7:0] w, output int acc);
    logic r;
    set_in(id, 1'b1, w);
    for (int i = 0; i < 300; i++) begin
      r   = rdy(id);
      acc = cyc;
      tick();
      if (r) begin
        exp_q[id].push_back(w);
        return;
      end
    end
    acc = -1;
    check("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int id, output int dc);
    for (int i = 0; i < 500; i++) begin
      if (dn(id)) begin
        dc = cyc;
        return;
      end
      tick();
    end
    dc = -1;
    check("done_timeout", 0, 1);
  endtask

  task automatic drain(input int id, input string name);
    check({name, "_count"}, rx_q[id].size(), exp_q[id].size());
    while (exp_q[id].size() > 0 && rx_q[id].size() > 0)
      check(name, int'(rx_q[id].pop_front()), int'(exp_q[id].pop_front()));
    exp_q[id].delete();
    rx_q[id].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, dc, r0, d0, bad, chg_bad, k_ok;
    logic r, s, d, prev_s, prev_d;
    logic [7:0] w;
    int accs[$];
    int dcs[$];

    vecs[0] = '{8'hA5, 8'hA5, 17};
    vecs[1] = '{8'h01, 8'h80, 17};
    vecs[2] = '{8'h0F, 8'hF0, 17};
    vecs[3] = '{8'h12, 8'h48, 17};
    vecs[4] = '{8'h6E, 8'h76, 17};
    vecs[5] = '{8'h80, 8'h01, 17};

    // reset with word_valid asserted
    for (int id = 0; id < 3; id++) set_in(id, 1'b1, 8'hFF);
    #1 rst = 1'b1;
    repeat (3) tick();
    for (int id = 0; id < 3; id++) check("reset_outputs", int'(stat(id)), 0);
    for (int id = 0; id < 3; id++) set_in(id, 1'b0, 8'h00);
    rst = 1'b0;
    tick();
    for (int id = 0; id < 3; id++) check("ready_after_release", int'(rdy(id)), 1);

    // single-word frames, HALF=1
    for (int v = 0; v < 6; v++) begin
      r0 = rises_a;
      d0 = dones_a;
      send(0, vecs[v].word, acc);
      set_in(0, 1'b0, 8'h00);
      wait_done(0, dc);
      check("t2_latency", dc - acc, vecs[v].lat);
      check("t2_busy_at_done", int'(busy_a), 1);
      check("t2_rises", rises_a - r0, 8);
      check("t2_sdo_seq", int'(seq_a), int'(vecs[v].seq));
      tick();
      check("t2_after_done", int'({busy_a, sdo_a, done_a, bus_a.word_ready}), 4'b0001);
      check("t2_done_pulses", dones_a - d0, 1);
      drain(0, "t2_word");
    end

    // 4-word frame with a withheld word
    r0 = rises_b;
    d0 = dones_b;
    send(1, 8'h01, acc);
    send(1, 8'h80, acc1);
    check("t3_back_to_back", acc1 - acc, 17);
    set_in(1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (rdy(1)) break;
      tick();
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(rdy(1) && !sclk_b && sdo_b)) bad++;
      tick();
    end
    check("t3_gap_flat", bad, 0);
    send(1, 8'hFF, acc);
    send(1, 8'h3C, acc);
    set_in(1, 1'b0, 8'h00);
    wait_done(1, dc);
    check("t3_rises", rises_b - r0, 32);
    repeat (3) tick();
    check("t3_done_pulses", dones_b - d0, 1);
    drain(1, "t3_word");

    // valid held high, word_in changing every cycle, two back-to-back frames
    for (int i = 0; i < 600 && dcs.size() < 2; i++) begin
      w = 8'($urandom);
      set_in(1, 1'b1, w);
      r = rdy(1);
      if (dn(1)) dcs.push_back(cyc);
      acc = cyc;
      tick();
      if (r) begin
        exp_q[1].push_back(w);
        accs.push_back(acc);
      end
    end
    set_in(1, 1'b0, 8'h00);
    check("t6_frames", dcs.size(), 2);
    check("t6_accepts", accs.size(), 8);
    if (dcs.size() >= 1 && accs.size() >= 5) begin
      check("t6_frame_len", dcs[0] - accs[0], 68);
      check("t6_restart", accs[4] - dcs[0], 1);
    end
    tick();
    drain(1, "t6_word");

    // HALF=3 waveform, 2-word frame
    r0 = rises_c;
    w  = 8'h0F;
    send(2, w, acc);
    set_in(2, 1'b0, 8'h00);
    bad = 0;
    chg_bad = 0;
    prev_s = 1'b0;
    prev_d = 1'b0;
    for (int k = 0; k < 48; k++) begin
      s = sclk_c;
      d = sdo_c;
      k_ok = (k / 3) % 2;
      if (int'(s) != k_ok) bad++;
      if (d !== w[k / 6]) bad++;
      if (k > 0 && d !== prev_d && !(prev_s && !s)) chg_bad++;
      prev_s = s;
      prev_d = d;
      tick();
    end
    check("t4_waveform", bad, 0);
    check("t4_sdo_change", chg_bad, 0);
    check("t4_load_state", int'({sclk_c, bus_c.word_ready}), 2'b01);
    send(2, 8'h5A, acc1);
    check("t4_second_accept", acc1 - acc, 49);
    set_in(2, 1'b0, 8'h00);
    wait_done(2, dc);
    check("t4_frame_len", dc - acc, 98);
    check("t4_rises", rises_c - r0, 16);
    tick();
    drain(2, "t4_word");

    // reset after the third sclk rise of word 0
    r0 = rises_c;
    d0 = dones_c;
    send(2, 8'h3C, acc);
    set_in(2, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (rises_c - r0 >= 3) break;
      tick();
    end
    check("t5_high_before_reset", int'(sclk_c), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_reset_immediate", int'(stat(2)), 0);
    exp_q[2].delete();
    rx_q[2].delete();
    tick();
    rst = 1'b0;
    tick();
    check("t5_ready_after_reset", int'(rdy(2)), 1);
    check("t5_no_done_on_abort", dones_c - d0, 0);
    r0 = rises_c;
    send(2, 8'h96, acc);
    send(2, 8'hC3, acc1);
    set_in(2, 1'b0, 8'h00);
    wait_done(2, dc);
    check("t5_frame_len", dc - acc, 98);
    check("t5_rises", rises_c - r0, 16);
    tick();
    drain(2, "t5_word");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
